inport_req: RTL

INPORT_REQ -- requirements
Module: inport_req

---
 rtl/inport_req_pkg.sv | 49 ++++
 rtl/inport_fifo.sv | 68 ++++++
 rtl/inport_req.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/inport_req_pkg.sv
// Shared definitions for the router input port.
//   `PORT       : highest output index; masks are `PORT+1 bits wide.
//   P_NORTH..P_EJECT : output bit positions.
//   PRIO        : fixed single-output priority, highest first (4,3,0,1,2).
//   state_e     : input-port FSM encoding.
//   prio_pick   : keeps only the highest-priority set bit of a mask.
//   multi_hot   : true when more than one mask bit is set.
`ifndef PORT
`define PORT 4
`endif

package inport_req_pkg;

  localparam int unsigned NP = `PORT + 1;

  localparam int unsigned P_NORTH = 0;
  localparam int unsigned P_EAST  = 1;
  localparam int unsigned P_SOUTH = 2;
  localparam int unsigned P_WEST  = 3;
  localparam int unsigned P_EJECT = 4;

  localparam int unsigned PRIO [NP] = '{P_EJECT, P_WEST, P_NORTH, P_EAST, P_SOUTH};

  typedef logic [`PORT:0] mask_t;

  typedef enum logic {
    ST_IDLE,
    ST_REQ
  } state_e;

  function automatic mask_t prio_pick(input mask_t m);
    mask_t r;
    logic  found;
    r     = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NP; i++) begin
      if (!found && m[PRIO[i]]) begin
        r[PRIO[i]] = 1'b1;
        found      = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic multi_hot(input mask_t m);
    return (m & (m - mask_t'(1))) != '0;
  endfunction

endpackage

// File: rtl/inport_fifo.sv
// Circular flit buffer for the input port.
//   clk, rst  : clock, synchronous active-high reset (pointers/occupancy only).
//   push_i    : write wdata_i (caller guarantees not full).
//   pop_i     : drop the head entry (caller guarantees not empty).
//   wdata_i   : entry to store.
//   rdata_o   : head entry.
//   rnext_o   : top TAG_W bits of the entry behind the head (valid when occ>1).
//   full_o, empty_o, occ_o : status.
module inport_fifo #(
  parameter int unsigned W     = 37,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             wdata_i,
  output logic [W-1:0]             rdata_o,
  output logic [TAG_W-1:0]         rnext_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   occ_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned OW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [OW-1:0] occ_q, occ_d;
  logic [AW-1:0] rd_next;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_i && !pop_i)      occ_d = occ_q + OW'(1);
    else if (pop_i && !push_i) occ_d = occ_q - OW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rd_next = rd_ptr_q + AW'(1);
  assign rdata_o = mem_q[rd_ptr_q];
  assign rnext_o = mem_q[rd_next][W-1 -: TAG_W];
  assign full_o  = (occ_q == OW'(DEPTH));
  assign empty_o = (occ_q == '0);
  assign occ_o   = occ_q;

endmodule

// File: rtl/inport_req.sv
// Router input port: buffers flits and requests the output arbiters for the
// head flit until every destination in its mask has been granted.
//   clk, rst  : clock, synchronous active-high reset.
//   in_vld/in_rdy/in_data/in_mask : upstream flit handshake.
//   req       : outputs the head flit still needs.
//   grt       : grants from the output arbiters.
//   out_data  : head payload (zero when idle).
//   sent      : outputs served this cycle (req & grt).
//   starve    : head has waited STARVE_TH or more cycles without service.
//   err       : one-cycle pulse for zero mask, stray grant, or reduced mask.
//   occ       : buffered flit count.
// Build option: INPORT_MULTICAST_EN allows multi-bit masks; otherwise a
// multi-bit mask is reduced to its highest-priority bit and flagged.
module inport_req
  import inport_req_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned STARVE_TH = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_vld,
  output logic                   in_rdy,
  input  logic [DATA_W-1:0]      in_data,
  input  logic [`PORT:0]         in_mask,
  output logic [`PORT:0]         req,
  input  logic [`PORT:0]         grt,
  output logic [DATA_W-1:0]      out_data,
  output logic [`PORT:0]         sent,
  output logic                   starve,
  output logic                   err,
  output logic [$clog2(DEPTH):0] occ
);

  localparam int unsigned OW = $clog2(DEPTH) + 1;
  localparam int unsigned CW = $clog2(STARVE_TH) + 1;
  localparam int unsigned FW = DATA_W + NP;

  state_e        state_q, state_d;
  mask_t         pend_q, pend_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  mask_t         st_mask;
  logic          mc_err;
  logic          accept, push, pop;
  logic          full, empty;
  logic [FW-1:0] head;
  mask_t         next_mask;

`ifdef INPORT_MULTICAST_EN
  assign st_mask = in_mask;
  assign mc_err  = 1'b0;
`else
  assign st_mask = prio_pick(in_mask);
  assign mc_err  = multi_hot(in_mask);
`endif

  assign in_rdy = !full;
  assign accept = in_vld && in_rdy;
  assign push   = accept && (in_mask != '0);
  assign sent   = req & grt;
  assign pop    = (state_q == ST_REQ) && !empty && ((pend_q & ~grt) == '0);

  inport_fifo #(
    .W     (FW),
    .DEPTH (DEPTH),
    .TAG_W (NP)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({st_mask, in_data}),
    .rdata_o (head),
    .rnext_o (next_mask),
    .full_o  (full),
    .empty_o (empty),
    .occ_o   (occ)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state: a pop with another flit behind it (buffered, or arriving this
  // cycle) stays in REQ so req never drops for a cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (push) state_d = ST_REQ;
      ST_REQ:  if (pop && !(occ > OW'(1)) && !push) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    req      = '0;
    out_data = '0;
    if (state_q == ST_REQ) begin
      req      = pend_q;
      out_data = head[DATA_W-1:0];
    end
  end

  // Pending mask: when the head pops, the next head is either the buffered
  // entry behind it or, if the FIFO held only one flit, the flit pushed now.
  always_comb begin
    pend_d = pend_q;
    if (state_q == ST_IDLE) begin
      pend_d = push ? st_mask : '0;
    end else if (pop) begin
      if (occ > OW'(1)) pend_d = next_mask;
      else if (push)    pend_d = st_mask;
      else              pend_d = '0;
    end else begin
      pend_d = pend_q & ~sent;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_IDLE || pop || (sent != '0)) cnt_d = '0;
    else if (cnt_q != '1)                          cnt_d = cnt_q + CW'(1);
  end

  assign err_d = (accept && (in_mask == '0)) || ((grt & ~req) != '0) || (push && mc_err);

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign starve = (cnt_q >= CW'(STARVE_TH));
  assign err    = err_q;

endmodule
